// File: rtl/berger_pkg.sv
// Shared widths and FSM state encoding for the Berger-coded memory controller.
package berger_pkg;

    localparam int DATA_W  = 8;
    localparam int CHECK_W = 4;
    localparam int CODE_W  = DATA_W + CHECK_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/berger_mem_ctrl_if.sv
// Host request/response channels and synchronous RAM port of the Berger memory controller.
interface berger_mem_ctrl_if #(
    parameter int ADDR_W = 4
);
    import berger_pkg::*;

    // Both host channels: a transfer happens on a rising edge where valid and ready are
    // both 1; once raised, valid and its payload hold until that edge.
    logic                req_valid;
    logic                req_ready;
    logic                req_we;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [DATA_W-1:0]   rsp_data;
    logic                rsp_err;

    // RAM read data is valid the cycle after mem_en.
    logic                mem_en;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_addr;
    logic [CODE_W-1:0]   mem_wdata;
    logic [CODE_W-1:0]   mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_data, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_data, rsp_err, mem_en, mem_we, mem_addr, mem_wdata
    );

endinterface

// File: rtl/berger_zero_calc.sv
// Counts the zero bits of one data byte: the Berger check field for that byte.
module berger_zero_calc
    import berger_pkg::*;
(
    input  logic [DATA_W-1:0]  data,
    output logic [CHECK_W-1:0] zeros
);

    always_comb begin
        zeros = CHECK_W'(DATA_W);
        for (int i = 0; i < DATA_W; i++) begin
            zeros = zeros - CHECK_W'(data[i]);
        end
    end

endmodule

// File: rtl/berger_mem_ctrl.sv
// Berger-coded RAM controller: encodes host writes, checks every read, logs errors.
// Define BERGER_SCRUB_EN to add the background scrubber (timer, pointer, arbitration).
module berger_mem_ctrl
    import berger_pkg::*;
#(
    parameter int ADDR_W         = 4,
    parameter int SCRUB_INTERVAL = 255
) (
    input  logic                clk,
    input  logic                rst,
    berger_mem_ctrl_if.slave    bus,
    input  logic                err_clr,
    output logic                err_flag,
    output logic [7:0]          err_count,
    output logic [ADDR_W-1:0]   err_addr,
    output state_t              dbg_state
);

    state_t              state;
    logic                cur_we;
    logic                cur_scrub;
    logic                mem_en_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [CODE_W-1:0]   mem_wdata_q;
    logic                rsp_valid_q;
    logic [DATA_W-1:0]   rsp_data_q;
    logic                rsp_err_q;
    logic [CHECK_W-1:0]  enc_zeros;
    logic [CHECK_W-1:0]  chk_zeros;
    logic                chk_err;
    logic                host_fire;
    logic                scrub_grant;
    logic [ADDR_W-1:0]   scrub_addr;

    berger_zero_calc u_enc_zeros (
        .data  (bus.req_wdata),
        .zeros (enc_zeros)
    );

    berger_zero_calc u_chk_zeros (
        .data  (bus.mem_rdata[CODE_W-1:CHECK_W]),
        .zeros (chk_zeros)
    );

    // Field values 9..15 can never equal a real zero count, so they fail here too.
    assign chk_err       = (chk_zeros != bus.mem_rdata[CHECK_W-1:0]);
    assign bus.req_ready = (state == IDLE) && !scrub_grant;
    assign host_fire     = bus.req_valid && bus.req_ready;

`ifdef BERGER_SCRUB_EN
    localparam int TIMER_W = 16;

    logic [TIMER_W-1:0]  scrub_timer;
    logic [ADDR_W-1:0]   scrub_ptr;
    logic                scrub_pending;
    logic                host_served;
    logic                timer_wrap;

    assign timer_wrap  = (state == IDLE) && (scrub_timer == TIMER_W'(SCRUB_INTERVAL - 1));
    // A waiting host keeps the slot until one host transaction has gone through.
    assign scrub_grant = (state == IDLE) && scrub_pending && (!bus.req_valid || host_served);
    assign scrub_addr  = scrub_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            scrub_timer   <= '0;
            scrub_ptr     <= '0;
            scrub_pending <= 1'b0;
            host_served   <= 1'b0;
        end else begin
            if (state == IDLE) begin
                scrub_timer <= timer_wrap ? '0 : scrub_timer + TIMER_W'(1);
            end
            if (scrub_grant) begin
                scrub_pending <= 1'b0;
                host_served   <= 1'b0;
                scrub_ptr     <= scrub_ptr + ADDR_W'(1);
            end else if (host_fire && (scrub_pending || timer_wrap)) begin
                host_served <= 1'b1;
            end
            if (timer_wrap) begin
                scrub_pending <= 1'b1;
            end
        end
    end
`else
    assign scrub_grant = 1'b0;
    assign scrub_addr  = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            cur_we      <= 1'b0;
            cur_scrub   <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (scrub_grant) begin
                        state      <= ISSUE;
                        mem_en_q   <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= scrub_addr;
                        cur_we     <= 1'b0;
                        cur_scrub  <= 1'b1;
                    end else if (host_fire) begin
                        state       <= ISSUE;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.req_we;
                        mem_addr_q  <= bus.req_addr;
                        mem_wdata_q <= bus.req_we ? {bus.req_wdata, enc_zeros} : '0;
                        cur_we      <= bus.req_we;
                        cur_scrub   <= 1'b0;
                    end
                end
                ISSUE: begin
                    mem_en_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    state    <= cur_we ? IDLE : CHECK;
                end
                CHECK: begin
                    if (cur_scrub) begin
                        state <= IDLE;
                    end else begin
                        state       <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus.mem_rdata[CODE_W-1:CHECK_W];
                        rsp_err_q   <= chk_err;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mem_addr_q still holds the checked address during CHECK.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag  <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end else if ((state == CHECK) && chk_err) begin
            err_flag  <= 1'b1;
            err_count <= err_clr ? 8'd1 : ((err_count == 8'hFF) ? 8'hFF : err_count + 8'd1);
            err_addr  <= mem_addr_q;
        end else if (err_clr) begin
            err_flag  <= 1'b0;
            err_count <= '0;
            err_addr  <= '0;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign dbg_state     = state;

endmodule

// File: tb/tb_berger_mem_ctrl.sv
// Randomized bench for berger_mem_ctrl: RAM model, transaction-level error model, scoreboard.
module tb_berger_mem_ctrl;
  import berger_pkg::*;

  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          err_clr = 1'b0;
  logic          err_flag;
  logic [7:0]    err_count;
  logic [AW-1:0] err_addr;
  state_t        dbg_state;

  berger_mem_ctrl_if #(.ADDR_W(AW)) bus ();

  berger_mem_ctrl #(.ADDR_W(AW), .SCRUB_INTERVAL(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus.slave),
    .err_clr   (err_clr),
    .err_flag  (err_flag),
    .err_count (err_count),
    .err_addr  (err_addr),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference models ----------------
  int            n_checks = 0;
  int            n_errors = 0;
  logic [11:0]   ram [DEPTH];
  logic [11:0]   model_mem [DEPTH];
  logic [7:0]    exp_q [$];
  bit            m_flag = 0;
  int            m_count = 0;
  logic [AW-1:0] m_addr = '0;
  bit            rd_pend = 0;
  logic [AW-1:0] rd_addr = '0;

  function automatic logic [11:0] encode(logic [7:0] d);
    return {d, 4'(8 - $countones(d))};
  endfunction

  function automatic bit code_bad(logic [11:0] c);
    return (8 - $countones(c[11:4])) != int'(c[3:0]);
  endfunction

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Synchronous RAM: data returned the cycle after the enable.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= ram[bus.mem_addr];
    end
  end

  // Error log model: every word the controller reads is judged against the Berger rule.
  always @(posedge clk) begin
    bit bad;
    if (rst) begin
      m_flag  = 0;
      m_count = 0;
      m_addr  = '0;
      rd_pend = 0;
    end else begin
      bad = rd_pend && code_bad(bus.mem_rdata);
      if (bad) begin
        m_flag  = 1;
        m_count = err_clr ? 1 : ((m_count >= 255) ? 255 : m_count + 1);
        m_addr  = rd_addr;
      end else if (err_clr) begin
        m_flag  = 0;
        m_count = 0;
        m_addr  = '0;
      end
      rd_pend = bus.mem_en && !bus.mem_we;
      rd_addr = bus.mem_addr;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check_err_regs(string tag);
    check_eq({tag, "_flag"},  err_flag,  m_flag);
    check_eq({tag, "_count"}, err_count, m_count);
    check_eq({tag, "_addr"},  err_addr,  m_addr);
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
  endtask

  task automatic inject(logic [AW-1:0] a, logic [11:0] raw);
    ram[a]       = raw;
    model_mem[a] = raw;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 0;
    for (int i = 0; i < 64; i++) begin
      #1;
      if (bus.req_ready) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
    if (!ok) check_eq("hs_timeout", bus.req_ready, 1'b1);
  endtask

  task automatic host_write(logic [AW-1:0] a, logic [7:0] d);
    bit ok;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = d;
    wait_ready(ok);
    if (!ok) begin
      bus.req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("wr_issue_en",    bus.mem_en,    1'b1);
    check_eq("wr_issue_we",    bus.mem_we,    1'b1);
    check_eq("wr_issue_addr",  bus.mem_addr,  a);
    check_eq("wr_issue_wdata", bus.mem_wdata, encode(d));
    bus.req_valid = 1'b0;
    model_mem[a]  = encode(d);
    @(negedge clk);
    check_eq("wr_done_state", dbg_state,  IDLE);
    check_eq("wr_done_en",    bus.mem_en, 1'b0);
  endtask

  // hold = number of RESP cycles with rsp_ready low (>= 1).
  task automatic host_read(logic [AW-1:0] a, int hold, bit clr_at_check, bit rst_in_resp);
    bit         ok;
    bit         exp_err;
    logic [7:0] exp_d;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b0;
    bus.req_addr  = a;
    exp_q.push_back(model_mem[a][11:4]);
    exp_err = code_bad(model_mem[a]);
    wait_ready(ok);
    if (!ok) begin
      bus.req_valid = 1'b0;
      void'(exp_q.pop_front());
      return;
    end
    @(posedge clk);
    @(negedge clk);
    check_eq("rd_issue_en",   bus.mem_en,   1'b1);
    check_eq("rd_issue_we",   bus.mem_we,   1'b0);
    check_eq("rd_issue_addr", bus.mem_addr, a);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check_eq("rd_check_state", dbg_state,     CHECK);
    check_eq("rd_check_en",    bus.mem_en,    1'b0);
    check_eq("rd_check_valid", bus.rsp_valid, 1'b0);
    if (clr_at_check) err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    exp_d = exp_q.pop_front();
    check_eq("rsp_valid", bus.rsp_valid, 1'b1);
    check_eq("rsp_data",  bus.rsp_data,  exp_d);
    check_eq("rsp_err",   bus.rsp_err,   exp_err);
    check_eq("rsp_ready_blocked", bus.req_ready, 1'b0);
    for (int i = 1; i < hold; i++) begin
      @(negedge clk);
      check_eq("hold_valid", bus.rsp_valid, 1'b1);
      check_eq("hold_data",  bus.rsp_data,  exp_d);
      check_eq("hold_err",   bus.rsp_err,   exp_err);
      check_eq("hold_req_ready", bus.req_ready, 1'b0);
    end
    if (rst_in_resp) begin
      rst = 1'b1;
      @(negedge clk);
      check_eq("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check_eq("rst_req_ready", bus.req_ready, 1'b1);
      check_eq("rst_mem_en",    bus.mem_en,    1'b0);
      rst = 1'b0;
      return;
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check_eq("done_valid", bus.rsp_valid, 1'b0);
    check_eq("done_state", dbg_state,     IDLE);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.req_valid = 1'b0;
    bus.req_we    = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) inject(AW'(i), encode(8'($urandom_range(0, 255))));

    repeat (3) @(negedge clk);
    check_eq("reset_req_ready", bus.req_ready, 1'b1);
    check_eq("reset_rsp_valid", bus.rsp_valid, 1'b0);
    check_eq("reset_mem_en",    bus.mem_en,    1'b0);
    check_eq("reset_mem_we",    bus.mem_we,    1'b0);
    check_eq("reset_state",     dbg_state,     IDLE);
    check_eq("reset_err_flag",  err_flag,      1'b0);
    check_eq("reset_err_count", err_count,     8'd0);
    check_eq("reset_err_addr",  err_addr,      '0);
    rst = 1'b0;

`ifdef BERGER_SCRUB_EN
    begin : scrub_walk
      int seen;
      seen = 0;
      for (int cyc = 0; cyc < 600 && seen < DEPTH + 1; cyc++) begin
        @(negedge clk);
        if (bus.mem_en && !bus.mem_we) begin
          check_eq("scrub_addr", bus.mem_addr, seen % DEPTH);
          seen++;
        end
      end
      check_eq("scrub_walk_count", seen, DEPTH + 1);
    end
`endif

    // Known codeword round trip.
    host_write(4'd3, 8'hA5);
    host_read(4'd3, 1, 0, 0);

    // A stored word whose check field disagrees with its data.
    pulse_clr();
    inject(4'd5, 12'hFF1);
    host_read(4'd5, 1, 0, 0);
`ifndef BERGER_SCRUB_EN
    check_eq("bad5_flag",  err_flag,  1'b1);
    check_eq("bad5_count", err_count, 8'd1);
    check_eq("bad5_addr",  err_addr,  4'd5);
`endif
    check_err_regs("bad5");

    // Response back-pressure for five cycles.
    host_read(4'd3, 5, 0, 0);

    // Clear landing on the same cycle as a detected error.
    host_read(4'd5, 1, 1, 0);
    check_eq("clr_coinc_count", err_count, 8'd1);
    check_eq("clr_coinc_flag",  err_flag,  1'b1);
    check_eq("clr_coinc_addr",  err_addr,  4'd5);

    // Reset while a response is waiting.
    host_read(4'd3, 2, 0, 1);
    check_err_regs("after_rst");

    // Random traffic with occasional corrupted words (check fields include 9..15).
    for (int n = 0; n < 60; n++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 3) == 0) inject(a, 12'($urandom_range(0, 4095)));
      if ($urandom_range(0, 1) == 1) host_write(a, 8'($urandom_range(0, 255)));
      else                           host_read(a, $urandom_range(1, 3), 0, 0);
      if ($urandom_range(0, 7) == 0) pulse_clr();
      check_err_regs("rand");
    end

    // Saturation through repeated host reads of a bad word.
    pulse_clr();
    inject(4'd9, 12'h0FF);
    for (int n = 0; n < 260; n++) host_read(4'd9, 1, 0, 0);
    check_eq("sat_count", err_count, 8'd255);
    check_err_regs("sat");

`ifdef BERGER_SCRUB_EN
    // Saturation through the scrubber alone.
    for (int i = 0; i < DEPTH; i++) inject(AW'(i), 12'hFFF);
    pulse_clr();
    repeat (2200) @(negedge clk);
    check_eq("scrub_sat_count", err_count, 8'd255);
    check_err_regs("scrub_sat");
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/berger_mem_ctrl.md
BERGER_MEM_CTRL -- requirements
Module: berger_mem_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, memory address width (2^ADDR_W words of 12 bits).
REQ-002 SHALL have parameter SCRUB_INTERVAL, default 255, idle cycles between scrub reads (range 1..65535).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports req_valid in 1, req_ready out 1, req_we in 1, req_addr in ADDR_W, req_wdata in 8: host request channel.
REQ-006 SHALL have ports rsp_valid out 1, rsp_ready in 1, rsp_data out 8, rsp_err out 1: host read-response channel.
REQ-007 SHALL have ports mem_en out 1, mem_we out 1, mem_addr out ADDR_W, mem_wdata out 12, mem_rdata in 12: synchronous RAM port; read data valid one cycle after mem_en.
REQ-008 SHALL have ports err_clr in 1, err_flag out 1 (sticky), err_count out 8 (saturating), err_addr out ADDR_W (last failing address).

Function
REQ-009 Codeword SHALL be {data[7:0], zeros[3:0]}, zeros = 8 minus popcount(data); check field range 0..8.
REQ-010 Check SHALL flag error when zeros(mem_rdata[11:4]) != mem_rdata[3:0], including field values 9..15.
REQ-011 FSM states SHALL be IDLE, ISSUE, CHECK, RESP.
REQ-012 req_ready SHALL be 1 only in IDLE when no scrub slot is granted that cycle.
REQ-013 Handshake at cycle T: ISSUE at T+1 with mem_en=1, mem_addr=req_addr, registered outputs.
REQ-014 Write: mem_we=1, mem_wdata=encoded codeword in ISSUE; return to IDLE at T+2; no response generated.
REQ-015 Read: CHECK at T+2 samples mem_rdata; RESP from T+3 with rsp_valid=1, rsp_data=mem_rdata[11:4], rsp_err=check result.
REQ-016 rsp_valid/rsp_data/rsp_err SHALL hold stable until rsp_valid&rsp_ready; then IDLE next cycle.
REQ-017 mem_en SHALL be 0 in all states except ISSUE; mem_we 0 except write ISSUE.
REQ-018 Scrub timer SHALL count cycles in IDLE; at SCRUB_INTERVAL a scrub becomes pending and timer restarts at 0.
REQ-019 Arbitration: host wins over pending scrub, but after one host transaction completes a pending scrub SHALL take the next IDLE slot (req_ready=0 that cycle).
REQ-020 Scrub: ISSUE read at scrub_ptr, CHECK, back to IDLE; no response; scrub_ptr increments, wrapping 2^ADDR_W-1 -> 0.
REQ-021 Any CHECK error (host or scrub): err_flag=1, err_count+1 saturating at 255, err_addr=checked address.
REQ-022 err_clr SHALL zero err_flag, err_count, err_addr; if coincident with a CHECK error, the error wins (count=1, flag=1, addr new).

Reset
REQ-023 rst SHALL force IDLE, outputs 0 (req_ready 1 from first cycle after reset), timer 0, scrub_ptr 0, no scrub pending, error state 0.
REQ-024 rst mid-transaction SHALL abandon it: no rsp_valid, no further mem_en.

Configuration
REQ-025 Macro BERGER_SCRUB_EN: defined -> scrub timer, pointer, arbitration present; undefined -> no scrub logic, SCRUB_INTERVAL ignored, only host transactions, req_ready=1 whenever IDLE.

Structure
REQ-026 Package berger_pkg SHALL hold DATA_W=8, CHECK_W=4, CODE_W=12 and the FSM state enum.
REQ-027 Sub-module berger_zero_calc (combinational zeros count of 8 bits) SHALL be instantiated twice: encode path and check path.

Verification
REQ-028 Write addr 3 data 0xA5 -> ISSUE mem_wdata=0xA54, mem_we=1; read addr 3 -> rsp_data=0xA5, rsp_err=0 at T+3.
REQ-029 RAM returns 0xFF1 on read addr 5 -> rsp_err=1, err_flag=1, err_count=1, err_addr=5.
REQ-030 rsp_ready held 0 five cycles -> rsp outputs stable, req_ready=0 throughout; accepted on 6th.
REQ-031 BERGER_SCRUB_EN, SCRUB_INTERVAL=4, no host traffic -> scrub reads addr 0,1,..,15,0 (wrap); saturation after 256 injected errors holds 255.
REQ-032 err_clr coincident with error -> err_count=1; rst during RESP -> rsp_valid=0 next cycle, req_ready=1.
